// File: rtl/fall_pulse_if.sv
// fall_pulse_if
//   Bundles the request strobe and line/status outputs of the falling-edge
//   pulse transmitter.
//   Ports (through modports):
//     req      : one-cycle request strobe into the transmitter
//     sig_out  : idle-high line, pulsed low once per request
//     busy     : transmitter is not idle
//     pend_cnt : number of queued requests waiting for a pulse slot
//     req_drop : one-cycle flag, a request was lost at saturation
//   slave  = transmitter side, master = requester side.
interface fall_pulse_if #(
  parameter int PEND_W = 4
);
  logic              req;
  logic              sig_out;
  logic              busy;
  logic [PEND_W-1:0] pend_cnt;
  logic              req_drop;

  modport master (
    output req,
    input  sig_out,
    input  busy,
    input  pend_cnt,
    input  req_drop
  );

  modport slave (
    input  req,
    output sig_out,
    output busy,
    output pend_cnt,
    output req_drop
  );
endinterface

// File: rtl/fall_pulse_tx.sv
// fall_pulse_tx
//   Turns single-cycle request strobes into minimum-width active-low pulses
//   on an idle-high line so that a receiver in another clock domain can
//   double-flop the line and see every falling edge exactly once. Requests
//   arriving while a pulse (or its trailing gap) is in flight are queued in
//   a saturating counter and replayed back to back.
//   Ports:
//     clk        : clock, all state on the rising edge
//     rst        : synchronous active-high reset
//     bus.req    : request strobe (one request per high cycle)
//     bus.sig_out: registered line output, low for LOW_CYCLES per request
//     bus.busy   : state is not IDLE
//     bus.pend_cnt: queued requests (registered)
//     bus.req_drop: high the cycle after a request was discarded
module fall_pulse_tx #(
  parameter int LOW_CYCLES = 4,
  parameter int GAP_CYCLES = 4,
  parameter int PEND_W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  fall_pulse_if.slave  bus
);

  localparam int MAX_CYC = (LOW_CYCLES > GAP_CYCLES) ? LOW_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0]  LOW_LOAD = CNT_W'(LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              drop_q, drop_d;
  logic              sig_q;
  logic              last_cyc;
  logic              inc, dec;

  // Saturating pending-counter update. Returns {dropped, next_count}.
  // A request that coincides with a dequeue is absorbed by it, so it can
  // never be dropped even when the counter is full.
  function automatic logic [PEND_W:0] pend_next(
    input logic [PEND_W-1:0] cur,
    input logic              up,
    input logic              down
  );
    logic [PEND_W:0] r;
    r = {1'b0, cur};
    if (up && !down) begin
      if (cur == PEND_MAX) r = {1'b1, cur};
      else                 r = {1'b0, cur + 1'b1};
    end else if (!up && down) begin
      r = {1'b0, cur - 1'b1};
    end
    return r;
  endfunction

  assign last_cyc = (cnt_q == '0);

  // Requests seen while a pulse or gap is running are queued. At the end of
  // the gap one queued request is consumed; a request landing on that very
  // cycle with an empty queue is counted and consumed at once, which chains
  // straight into the next LOW without an IDLE cycle.
  assign inc = bus.req && (state_q != IDLE);
  assign dec = (state_q == GAP) && last_cyc && ((pend_q != '0) || bus.req);

  always_comb begin
    state_d = state_q;
    cnt_d   = last_cyc ? cnt_q : cnt_q - 1'b1;
    {drop_d, pend_d} = pend_next(pend_q, inc, dec);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.req) begin
          state_d = LOW;
          cnt_d   = LOW_LOAD;
        end
      end
      LOW: begin
        if (last_cyc) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end
      end
      GAP: begin
        if (last_cyc) begin
          if (dec) begin
            state_d = LOW;
            cnt_d   = LOW_LOAD;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State register; the line is its own flop decoded from the next state so
  // nothing combinational sits between req and the pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      drop_q  <= 1'b0;
      sig_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      sig_q   <= (state_d != LOW);
    end
  end

  assign bus.sig_out  = sig_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.pend_cnt = pend_q;
  assign bus.req_drop = drop_q;

endmodule
